regfile_tag_table: RTL

Architectural register file with a per-register rename-tag table (busy bit plus ROB tag). It is the receiving end of the ROB commit and flush interface. The issue stage uses it to look up operands and to mark destination registers. The ROB commits results into it and, after a branch mispredict, triggers a multi-cycle recovery scan that clears rename tags pointing at squashed ROB entries.

---
 rtl/regfile_tag_table.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/regfile_tag_table.sv
// Architectural register file with per-register rename tags (busy + ROB tag),
// commit bypass on reads, and a multi-cycle flush recovery scan.

module regfile_tag_entry #(
    parameter int ROB_DEPTH = 8,
    parameter int TAG_W     = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 commit_hit,
    input  logic [TAG_W-1:0]     commit_tag,
    input  logic [31:0]          commit_data,
    input  logic                 alloc_hit,
    input  logic [TAG_W-1:0]     alloc_tag,
    input  logic                 scan_hit,
    input  logic [ROB_DEPTH-1:0] mask,
    output logic [31:0]          data,
    output logic                 busy,
    output logic [TAG_W-1:0]     tag
);
    logic commit_clr;
    logic scan_clr;

    assign commit_clr = commit_hit && busy && (tag == commit_tag);
    assign scan_clr   = scan_hit && busy && mask[tag];

    // A fresh rename beats any clear landing in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            data <= '0;
            busy <= 1'b0;
            tag  <= '0;
        end else begin
            if (commit_hit)
                data <= commit_data;
            if (alloc_hit) begin
                busy <= 1'b1;
                tag  <= alloc_tag;
            end else if (commit_clr || scan_clr) begin
                busy <= 1'b0;
            end
        end
    end
endmodule

module regfile_tag_table #(
    parameter int ROB_DEPTH      = 8,
    parameter int TAG_W          = 3,
    parameter int SCAN_PER_CYCLE = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           rs1_addr,
    input  logic [4:0]           rs2_addr,
    output logic [31:0]          rs1_data,
    output logic                 rs1_busy,
    output logic [TAG_W-1:0]     rs1_tag,
    output logic [31:0]          rs2_data,
    output logic                 rs2_busy,
    output logic [TAG_W-1:0]     rs2_tag,
    input  logic                 alloc_valid,
    input  logic [4:0]           alloc_rd,
    input  logic [TAG_W-1:0]     alloc_tag,
    input  logic                 commit_valid,
    input  logic [4:0]           commit_rd,
    input  logic [TAG_W-1:0]     commit_tag,
    input  logic [31:0]          commit_data,
    input  logic                 flush_start,
    input  logic [ROB_DEPTH-1:0] flush_inv_mask,
    output logic                 recover_busy,
    output logic                 recover_done
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;
    localparam logic [4:0] LAST_IDX = 5'(32 - SCAN_PER_CYCLE);
    localparam logic [4:0] IDX_STEP = 5'(SCAN_PER_CYCLE);

    typedef struct packed {
        logic [31:0]      data;
        logic             busy;
        logic [TAG_W-1:0] tag;
    } rd_t;

    logic [0:0]               state;
    logic [4:0]               idx;
    logic [ROB_DEPTH-1:0]     mask;
    logic                     done_q;
    logic [31:0][31:0]        data_q;
    logic [31:0]              busy_q;
    logic [31:0][TAG_W-1:0]   tag_q;
    logic                     scanning;
    rd_t                      rd1;
    rd_t                      rd2;

    assign scanning = (state == SCAN);

    for (genvar i = 0; i < 32; i++) begin : g_reg
        logic [4:0] off;
        logic       commit_hit;
        logic       alloc_hit;
        logic       scan_hit;

        // x0 never receives a hit, so its storage stays at reset value.
        assign off        = 5'(i) - idx;
        assign commit_hit = (i != 0) && commit_valid && (commit_rd == 5'(i));
        assign alloc_hit  = (i != 0) && alloc_valid && !scanning && (alloc_rd == 5'(i));
        assign scan_hit   = scanning && ({1'b0, off} < 6'(SCAN_PER_CYCLE));

        regfile_tag_entry #(
            .ROB_DEPTH (ROB_DEPTH),
            .TAG_W     (TAG_W)
        ) u_entry (
            .clk         (clk),
            .rst         (rst),
            .commit_hit  (commit_hit),
            .commit_tag  (commit_tag),
            .commit_data (commit_data),
            .alloc_hit   (alloc_hit),
            .alloc_tag   (alloc_tag),
            .scan_hit    (scan_hit),
            .mask        (mask),
            .data        (data_q[i]),
            .busy        (busy_q[i]),
            .tag         (tag_q[i])
        );
    end

    // During a scan, squashed tags are hidden before the scan reaches them.
    function automatic rd_t read_port(input logic [4:0] addr);
        rd_t r;
        r.data = data_q[addr];
        r.tag  = tag_q[addr];
        r.busy = busy_q[addr] && !(scanning && mask[tag_q[addr]]);
        if (commit_valid && (commit_rd == addr) && busy_q[addr] &&
            (tag_q[addr] == commit_tag)) begin
            r.busy = 1'b0;
            r.data = commit_data;
        end
        if (addr == 5'd0) begin
            r.data = '0;
            r.busy = 1'b0;
        end
        return r;
    endfunction

    always_comb rd1 = read_port(rs1_addr);
    always_comb rd2 = read_port(rs2_addr);

    assign rs1_data = rd1.data;
    assign rs1_busy = rd1.busy;
    assign rs1_tag  = rd1.tag;
    assign rs2_data = rd2.data;
    assign rs2_busy = rd2.busy;
    assign rs2_tag  = rd2.tag;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            mask   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (flush_start) begin
                        mask  <= flush_inv_mask;
                        idx   <= '0;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    // A nested flush widens the mask and restarts the pass silently.
                    if (flush_start) begin
                        mask <= mask | flush_inv_mask;
                        idx  <= '0;
                    end else if (idx == LAST_IDX) begin
                        idx    <= '0;
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end else begin
                        idx <= idx + IDX_STEP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign recover_busy = scanning;
    assign recover_done = done_q;
endmodule
